alu_seq_nbit: RTL and testbench
===============================

Name: alu_seq_nbit

Overview:
- Parametrised N-bit successor to the team's 2-bit combinational ALU.
- Keeps the same aluop/funct decode and adds a multi-cycle unsigned shift-add multiply.
- Adds a valid/ready handshake on both sides, registered outputs and a zero flag.
- Sits between the instruction-decode stage and writeback; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), width of the multiply iteration counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- alu_op  in  1  0 forces ADD; 1 uses funct.
- funct  in  5  operation code.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operation result.
- carry_out  out  1  ADD carry, or MUL overflow.
- borrow_out  out  1  SUB borrow.
- zero  out  1  result == 0.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, result=0, carry_out=0, borrow_out=0, zero=0, counter=0, product=0.
- in_ready = (state==IDLE) && !rst. It is combinational from state.
- Decode (alu_op=1):
  - 01000 ADD
  - 00100 SUB
  - 00000 AND
  - 11000 OR
  - 10000 MUL
  - any other code: ADD
- Decode (alu_op=0): ADD regardless of funct.
- ADD: {carry_out,result} = a+b, computed with a true (WIDTH+1)-bit sum and full carry propagation.
- SUB: result = (a-b) mod 2^WIDTH; borrow_out = (a<b).
- AND and OR: bitwise; carry_out=0, borrow_out=0.
- MUL:
  - Uses a 2*WIDTH-bit product register and shift-add, one bit of b per cycle, LSB first.
  - result = product[WIDTH-1:0]; carry_out = |product[2*WIDTH-1:WIDTH]; borrow_out=0.
- Flags not produced by the selected op are 0. zero is computed from the final result for every op.
- FSM states: IDLE, MUL, DONE.
  - IDLE, on accept (in_valid && in_ready) with a non-MUL op: compute and register the outputs, go to DONE. out_valid rises the cycle after accept (latency 1).
  - IDLE, on accept with MUL: latch a and b, clear product, counter=0, go to MUL.
  - MUL: one iteration per cycle. After WIDTH iterations, register the outputs and go to DONE. out_valid rises WIDTH+1 cycles after the accept cycle.
  - DONE: out_valid=1. result and all flags are held stable while out_ready=0.
  - DONE, on out_ready=1: out_valid drops next cycle and state returns to IDLE. in_ready rises in that same next cycle, so there is no same-cycle turnaround.
- Inputs are ignored when in_ready=0. a, b and funct are sampled only at accept, so they may change during MUL without effect.
- rst asserted in any state, including mid-MUL, returns every register to its reset value on the next edge. The partial product is discarded and no out_valid is produced.
- in_valid asserted in the same cycle rst deasserts is not accepted, because in_ready=0 while rst=1.

Decomposition:
- Package alu_pkg holds:
  - funct code constants (FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_MUL);
  - a 3-bit op enum (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL);
  - the state enum (ST_IDLE, ST_MUL, ST_DONE).
- Sub-module alu_decode_nbit: purely combinational alu_op/funct -> op enum; it is the successor of the existing control decoder.
- Datapath and FSM live in alu_seq_nbit.

Test Plan (WIDTH=8):
- ADD, alu_op=1, funct=01000, a=200, b=100 -> one cycle later out_valid=1, result=44, carry_out=1, borrow_out=0, zero=0.
- SUB, funct=00100, a=5, b=9 -> result=252, borrow_out=1, carry_out=0. Then a=9, b=9 -> result=0, zero=1, borrow_out=0.
- Decode:
  - alu_op=0, funct=11000, a=3, b=4 -> result=7 (ADD forced).
  - alu_op=1, funct=10101, a=3, b=4 -> result=7 (default ADD).
  - funct=11000, a=0xA0, b=0x0C -> result=0xAC.
- MUL, funct=10000, a=15, b=17, accept at cycle t -> out_valid at t+9, result=255, carry_out=0. Then a=16, b=16 -> result=0, carry_out=1, zero=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses are ignored. out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- Reset: assert rst 4 cycles into a MUL of 255*255 -> next cycle state IDLE, all outputs 0. A following ADD 1+1 returns result=2 normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared decode constants and enums for the sequential N-bit ALU.
package alu_pkg;

    localparam logic [4:0] FUNCT_ADD = 5'b01000;
    localparam logic [4:0] FUNCT_SUB = 5'b00100;
    localparam logic [4:0] FUNCT_AND = 5'b00000;
    localparam logic [4:0] FUNCT_OR  = 5'b11000;
    localparam logic [4:0] FUNCT_MUL = 5'b10000;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_MUL
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DONE
    } state_e;

endpackage

// File: rtl/alu_decode_nbit.sv
// Combinational control decoder: alu_op/funct to ALU operation.
module alu_decode_nbit
    import alu_pkg::*;
(
    input  logic       alu_op,
    input  logic [4:0] funct,
    output op_e        op
);

    // Unknown codes and alu_op=0 both fall back to ADD.
    always_comb begin
        op = OP_ADD;
        if (alu_op) begin
            case (funct)
                FUNCT_ADD: op = OP_ADD;
                FUNCT_SUB: op = OP_SUB;
                FUNCT_AND: op = OP_AND;
                FUNCT_OR:  op = OP_OR;
                FUNCT_MUL: op = OP_MUL;
                default:   op = OP_ADD;
            endcase
        end
    end

endmodule

// File: rtl/alu_seq_nbit.sv
// N-bit ALU with valid/ready handshake, registered outputs and a
// multi-cycle shift-add unsigned multiply.
module alu_seq_nbit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             alu_op,
    input  logic [4:0]       funct,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             zero
);

    state_e             state;
    op_e                op;
    logic [WIDTH:0]     sum_full;
    logic [WIDTH-1:0]   calc_result;
    logic               calc_carry;
    logic               calc_borrow;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   counter;
    logic               accept;
    logic               last_iter;

    alu_decode_nbit u_decode (
        .alu_op (alu_op),
        .funct  (funct),
        .op     (op)
    );

    assign in_ready  = (state == ST_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign sum_full  = {1'b0, a} + {1'b0, b};
    assign last_iter = (counter == CNT_W'(WIDTH - 1));

    // The multiplicand shifts left and the multiplier right, so each step
    // only needs to look at the multiplier's LSB.
    assign mul_next = product + (mplier[0] ? mcand : '0);

    always_comb begin
        calc_result = sum_full[WIDTH-1:0];
        calc_carry  = sum_full[WIDTH];
        calc_borrow = 1'b0;
        case (op)
            OP_SUB: begin
                calc_result = a - b;
                calc_carry  = 1'b0;
                calc_borrow = (a < b);
            end
            OP_AND: begin
                calc_result = a & b;
                calc_carry  = 1'b0;
            end
            OP_OR: begin
                calc_result = a | b;
                calc_carry  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            out_valid  <= 1'b0;
            result     <= '0;
            carry_out  <= 1'b0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
            counter    <= '0;
            product    <= '0;
            mcand      <= '0;
            mplier     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            mcand   <= {{WIDTH{1'b0}}, a};
                            mplier  <= b;
                            product <= '0;
                            counter <= '0;
                            state   <= ST_MUL;
                        end else begin
                            result     <= calc_result;
                            carry_out  <= calc_carry;
                            borrow_out <= calc_borrow;
                            zero       <= (calc_result == '0);
                            out_valid  <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    product <= mul_next;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    counter <= counter + CNT_W'(1);
                    // The last step registers the outputs straight from mul_next.
                    if (last_iter) begin
                        result     <= mul_next[WIDTH-1:0];
                        carry_out  <= |mul_next[2*WIDTH-1:WIDTH];
                        borrow_out <= 1'b0;
                        zero       <= (mul_next[WIDTH-1:0] == '0);
                        out_valid  <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Directed self-checking bench for alu_seq_nbit at WIDTH=8.
module tb_alu_seq_nbit;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             alu_op;
    logic [4:0]       funct;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             borrow_out;
    logic             zero;

    int compare_count = 0;
    int fail_count    = 0;
    int lat;

    alu_seq_nbit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .alu_op     (alu_op),
        .funct      (funct),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .carry_out  (carry_out),
        .borrow_out (borrow_out),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compare_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] r, input logic c,
                                 input logic bo, input logic z);
        check({tag, "_result"}, 32'(result), 32'(r));
        check({tag, "_carry"},  32'(carry_out), 32'(c));
        check({tag, "_borrow"}, 32'(borrow_out), 32'(bo));
        check({tag, "_zero"},   32'(zero), 32'(z));
    endtask

    // Operands are scrambled right after accept to show they were latched.
    task automatic run_op(input logic op_sel, input logic [4:0] f, input logic [7:0] av,
                          input logic [7:0] bv, output int latency);
        alu_op   = op_sel;
        funct    = f;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        check("in_ready_at_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        a        = ~av;
        b        = ~bv;
        funct    = 5'b00100;
        latency  = 1;
        while (!out_valid && latency < 40) begin
            tick();
            latency++;
        end
        check("out_valid_rise", 32'(out_valid), 32'd1);
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_return", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        alu_op    = 1'b0;
        funct     = '0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check_outputs("rst", 8'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        run_op(1'b1, 5'b01000, 8'd200, 8'd100, lat);
        check("add_latency", 32'(lat), 32'd1);
        check_outputs("add_carry", 8'd44, 1'b1, 1'b0, 1'b0);
        release_out();

        run_op(1'b1, 5'b00100, 8'd5, 8'd9, lat);
        check("sub_latency", 32'(lat), 32'd1);
        check_outputs("sub_borrow", 8'd252, 1'b0, 1'b1, 1'b0);
        release_out();

        run_op(1'b1, 5'b00100, 8'd9, 8'd9, lat);
        check_outputs("sub_zero", 8'd0, 1'b0, 1'b0, 1'b1);
        release_out();

        run_op(1'b0, 5'b11000, 8'd3, 8'd4, lat);
        check_outputs("forced_add", 8'd7, 1'b0, 1'b0, 1'b0);
        release_out();

        run_op(1'b1, 5'b10101, 8'd3, 8'd4, lat);
        check_outputs("default_add", 8'd7, 1'b0, 1'b0, 1'b0);
        release_out();

        run_op(1'b1, 5'b11000, 8'hA0, 8'h0C, lat);
        check_outputs("or", 8'hAC, 1'b0, 1'b0, 1'b0);
        release_out();

        run_op(1'b1, 5'b00000, 8'hF0, 8'h3C, lat);
        check_outputs("and", 8'h30, 1'b0, 1'b0, 1'b0);
        release_out();

        run_op(1'b1, 5'b10000, 8'd15, 8'd17, lat);
        check("mul_latency", 32'(lat), 32'd9);
        check_outputs("mul_255", 8'd255, 1'b0, 1'b0, 1'b0);
        release_out();

        run_op(1'b1, 5'b10000, 8'd16, 8'd16, lat);
        check("mul_ovf_latency", 32'(lat), 32'd9);
        check_outputs("mul_ovf", 8'd0, 1'b1, 1'b0, 1'b1);
        release_out();

        // Backpressure: result held and new requests ignored while in DONE.
        run_op(1'b1, 5'b01000, 8'd7, 8'd8, lat);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            alu_op   = 1'b1;
            funct    = 5'b00100;
            a        = 8'd100;
            b        = 8'd1;
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check_outputs("bp_hold", 8'd15, 1'b0, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        release_out();
        tick();
        check("bp_no_ghost", 32'(out_valid), 32'd0);

        // Reset in the middle of a 255*255 multiply.
        alu_op   = 1'b1;
        funct    = 5'b10000;
        a        = 8'd255;
        b        = 8'd255;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mul_busy", 32'(out_valid), 32'd0);
        check("mul_busy_ready", 32'(in_ready), 32'd0);
        rst      = 1'b1;
        in_valid = 1'b1;
        funct    = 5'b01000;
        a        = 8'd1;
        b        = 8'd1;
        #1;
        check("in_ready_in_rst", 32'(in_ready), 32'd0);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check_outputs("midrst", 8'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("midrst_no_accept", 32'(out_valid), 32'd0);

        run_op(1'b1, 5'b01000, 8'd1, 8'd1, lat);
        check("post_rst_latency", 32'(lat), 32'd1);
        check_outputs("post_rst_add", 8'd2, 1'b0, 1'b0, 1'b0);
        release_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
